hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequences multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO into the 64-bit HI/LO register.
//  Sits in EX stage. Holds the pipeline with stall_o while an op is in flight.
//  Issues exactly one hilo_we pulse per committed instruction. Drops the result on flush.
// PARAMETERS
//  MUL_CYCLES  2   BUSY_MUL cycles before the product is valid (>=1)
//  DIV_ITERS   32  radix-2 divider iterations (== operand width)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  op_valid_i  in   1   EX instr is a HI/LO-writing op
//  op_i        in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO (others: no-op)
//  src_a_i     in   32  rs (dividend / multiplicand / MT value)
//  src_b_i     in   32  rt (divisor / multiplier)
//  hilo_cur_i  in   64  current {HI,LO}, used to merge MTHI/MTLO
//  flush_i     in   1   exception/eret flush of EX
//  stall_ext_i in   1   pipeline held by another source
//  stall_o     out  1   hold IF..EX
//  hilo_we_o   out  1   HI/LO write strobe
//  hilo_wdata_o out 64  {HI,LO} write data
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all operand/partial regs=0, stall_o=0, hilo_we_o=0, hilo_wdata_o=0.
//  FSM states: IDLE, BUSY_MUL, BUSY_DIV, DONE, HOLD.
//  - IDLE: mul/div with op_valid_i & ~flush_i -> latch operands and op, cnt=0.
//    MULT* goes to BUSY_MUL; DIV* goes to BUSY_DIV.
//  - IDLE: MTHI/MTLO with op_valid_i & ~flush_i & ~stall_ext_i -> same-cycle combinational write.
//    MTHI writes {src_a_i, hilo_cur_i[31:0]}; MTLO writes {hilo_cur_i[63:32], src_a_i}. No stall.
//  - BUSY_MUL: cnt++; at cnt==MUL_CYCLES-1 go to DONE.
//    Product: signed 33x33 (MULT) or zero-extended (MULTU), low 64 bits.
//  - BUSY_DIV: one restoring-divide iteration per cycle on |a|,|b| (magnitudes for signed DIV).
//    At cnt==DIV_ITERS-1 go to DONE.
//  - DONE: hilo_we_o=1 for one cycle with {rem,quot} or {prod_hi,prod_lo}.
//    Signed DIV fixup: quotient negated if sign(a)^sign(b); remainder takes sign(a).
//    Go to HOLD if stall_ext_i, else IDLE.
//  - HOLD: hilo_we_o=0; return to IDLE when ~stall_ext_i. Prevents re-issue of the same EX instr.
//  stall_o = (IDLE & op_valid_i & op is mul/div & ~flush_i) | BUSY_MUL | BUSY_DIV. Low in DONE/HOLD.
//  Latency, accept cycle to hilo_we_o: MUL_CYCLES+1 (mul), DIV_ITERS+1 (div).
//  Stall cycles: MUL_CYCLES+1 (mul), DIV_ITERS+1 (div).
//  Divide by zero: no trap; runs full length. Result: unsigned quot=0xFFFFFFFF, rem=a.
//  Signed divide by zero: apply the same fixup rules to the unsigned result.
//  0x80000000 / -1 (signed): quot=0x80000000, rem=0.
//  flush_i in any state: next state IDLE, hilo_we_o forced 0 that cycle, stall_o forced 0; in-flight result discarded.
//  op_valid_i/op_i changes while BUSY are ignored (operands already latched).
//  Async reset mid-operation: immediate return to reset values; no partial write.
// STRUCTURE
//  Shared package/defines header (the existing one): HILO_OP_* op encodings, FSM state localparams, widths.
//  Sub-module div_radix2_iter: 32-bit restoring divider. Iteration and partial remainder/quotient only.
//    Ports: clk, rst_n, start, a, b, step, quot, rem.
//  Multiplier stays inline; the synthesis tool retimes it across MUL_CYCLES.
// TESTING
//  1 MULT a=0xFFFFFFFE(-2) b=3 -> stall 3 cycles; hilo_we at cycle 3, wdata=0xFFFFFFFF_FFFFFFFA.
//  2 DIVU a=100 b=7 -> 33 stall cycles; single we, wdata={32'd2,32'd14}.
//    DIV a=-7 b=2 -> {0xFFFFFFFF,0xFFFFFFFD}.
//  3 MTHI a=0x12345678 with hilo_cur=0xAAAAAAAA_BBBBBBBB -> same-cycle we, wdata=0x12345678_BBBBBBBB, stall_o=0.
//  4 DIV started, flush_i at BUSY cycle 10 -> next cycle IDLE, stall_o=0, no we ever asserted.
//  5 MULTU done while stall_ext_i=1 for 4 cycles -> exactly one we pulse; FSM in HOLD; no restart with op_valid_i still high.
//  6 DIVU b=0 a=5 -> {32'd5,32'hFFFFFFFF}. rst_n low at BUSY cycle 5 -> all outputs 0 immediately, no we.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Package shared by the HI/LO multiply/divide controller slice.
// Holds the HI/LO op encodings, FSM state type, widths and small helper
// functions used to classify ops and take operand magnitudes.
package hilo_muldiv_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int HILO_W = 64;
    localparam int CNT_W  = 6;

    localparam logic [2:0] HILO_OP_MULT  = 3'd0;
    localparam logic [2:0] HILO_OP_MULTU = 3'd1;
    localparam logic [2:0] HILO_OP_DIV   = 3'd2;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd3;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUSY_MUL = 3'd1,
        ST_BUSY_DIV = 3'd2,
        ST_DONE     = 3'd3,
        ST_HOLD     = 3'd4
    } hilo_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
    endfunction

    function automatic logic is_mt(input logic [2:0] op);
        return (op == HILO_OP_MTHI) || (op == HILO_OP_MTLO);
    endfunction

    // Magnitude of v when treated as signed, raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO controller bundle.
// master: pipeline side (drives op request, flush, external stall, current HI/LO).
// slave : controller side (drives stall_o and the HI/LO write port).
interface hilo_muldiv_ctrl_if;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [63:0] hilo_cur_i;
    logic        flush_i;
    logic        stall_ext_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [63:0] hilo_wdata_o;

    modport master (
        output op_valid_i, op_i, src_a_i, src_b_i, hilo_cur_i, flush_i, stall_ext_i,
        input  stall_o, hilo_we_o, hilo_wdata_o
    );

    modport slave (
        input  op_valid_i, op_i, src_a_i, src_b_i, hilo_cur_i, flush_i, stall_ext_i,
        output stall_o, hilo_we_o, hilo_wdata_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl_div.sv
// div_radix2_iter: unsigned restoring divider, one quotient bit per step.
// Ports: clk, rst_n (async active-low), start (load a/b, clear remainder),
//        a (dividend), b (divisor), step (perform one iteration),
//        quot/rem (partial, final after W steps).
// Divide by zero falls out naturally: every trial subtract succeeds, giving
// quot = all ones and rem = a.
module div_radix2_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         step,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    logic [W-1:0] quot_r;
    logic [W-1:0] rem_r;
    logic [W-1:0] div_r;
    logic [W:0]   shifted_s;
    logic [W:0]   diff_s;
    logic         ge_s;

    // Trial subtract of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_s = {rem_r, quot_r[W-1]};
        diff_s    = shifted_s - {1'b0, div_r};
        ge_s      = (shifted_s >= {1'b0, div_r});
    end

    // Operand load and per-step quotient/remainder update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_r <= {W{1'b0}};
            rem_r  <= {W{1'b0}};
            div_r  <= {W{1'b0}};
        end else if (start) begin
            quot_r <= a;
            rem_r  <= {W{1'b0}};
            div_r  <= b;
        end else if (step) begin
            if (ge_s) begin
                rem_r  <= diff_s[W-1:0];
                quot_r <= {quot_r[W-2:0], 1'b1};
            end else begin
                rem_r  <= shifted_s[W-1:0];
                quot_r <= {quot_r[W-2:0], 1'b0};
            end
        end
    end

    assign quot = quot_r;
    assign rem  = rem_r;
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage sequencer for MULT/MULTU/DIV/DIVU (multi-cycle)
// and MTHI/MTLO (same-cycle) writes into the 64-bit {HI,LO} register.
// Ports: clk, rst_n (async active-low), bus (slave modport of
// hilo_muldiv_ctrl_if: op request, operands, current HI/LO, flush,
// external stall in; stall_o, hilo_we_o, hilo_wdata_o out).
// One hilo_we_o pulse per committed op; a flush discards any in-flight result.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hilo_muldiv_ctrl_if.slave     bus
);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    hilo_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_r, b_r;

    logic              accept_s, mt_we_s, div_start_s, div_step_s;
    logic              op_signed_s, neg_q_s, neg_r_s;
    logic [HILO_W-1:0] mul_a_s, mul_b_s, prod_s, div_res_s, mt_data_s;
    logic [XLEN-1:0]   quot_s, rem_s;

    // Request decode: multi-cycle accept and same-cycle MTHI/MTLO write.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && bus.op_valid_i && !bus.flush_i &&
                      (is_mul(bus.op_i) || is_div(bus.op_i));
        mt_we_s     = (state_r == ST_IDLE) && bus.op_valid_i && !bus.flush_i &&
                      !bus.stall_ext_i && is_mt(bus.op_i);
        div_start_s = accept_s && is_div(bus.op_i);
        div_step_s  = (state_r == ST_BUSY_DIV);
        op_signed_s = (bus.op_i == HILO_OP_DIV);
        if (bus.op_i == HILO_OP_MTHI) begin
            mt_data_s = {bus.src_a_i, bus.hilo_cur_i[31:0]};
        end else begin
            mt_data_s = {bus.hilo_cur_i[63:32], bus.src_a_i};
        end
    end

    div_radix2_iter #(.W(XLEN)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start_s),
        .a     (mag32(bus.src_a_i, op_signed_s)),
        .b     (mag32(bus.src_b_i, op_signed_s)),
        .step  (div_step_s),
        .quot  (quot_s),
        .rem   (rem_s)
    );

    // Result datapath: low 64 bits of the sign/zero-extended product, and
    // signed fixup of the magnitude divide (quotient sign a^b, remainder sign a).
    always_comb begin
        mul_a_s   = {{32{(op_r == HILO_OP_MULT) && a_r[31]}}, a_r};
        mul_b_s   = {{32{(op_r == HILO_OP_MULT) && b_r[31]}}, b_r};
        prod_s    = mul_a_s * mul_b_s;
        neg_q_s   = (op_r == HILO_OP_DIV) && (a_r[31] ^ b_r[31]);
        neg_r_s   = (op_r == HILO_OP_DIV) && a_r[31];
        div_res_s = {(neg_r_s ? (32'd0 - rem_s) : rem_s),
                     (neg_q_s ? (32'd0 - quot_s) : quot_s)};
    end

    // Next-state and counter logic; flush returns to IDLE from any state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (bus.flush_i) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = is_mul(bus.op_i) ? ST_BUSY_MUL : ST_BUSY_DIV;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY_MUL: begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == MUL_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY_MUL;
                    end
                end
                ST_BUSY_DIV: begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == DIV_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY_DIV;
                    end
                end
                // HOLD keeps the still-present EX instruction from re-issuing.
                ST_DONE: state_nxt_s = bus.stall_ext_i ? ST_HOLD : ST_IDLE;
                ST_HOLD: state_nxt_s = bus.stall_ext_i ? ST_HOLD : ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: stall while accepting or busy, single write pulse in DONE.
    always_comb begin
        bus.stall_o      = accept_s || (!bus.flush_i &&
                           ((state_r == ST_BUSY_MUL) || (state_r == ST_BUSY_DIV)));
        bus.hilo_we_o    = 1'b0;
        bus.hilo_wdata_o = {HILO_W{1'b0}};
        if ((state_r == ST_DONE) && !bus.flush_i) begin
            bus.hilo_we_o    = 1'b1;
            bus.hilo_wdata_o = is_mul(op_r) ? prod_s : div_res_s;
        end else if (mt_we_s) begin
            bus.hilo_we_o    = 1'b1;
            bus.hilo_wdata_o = mt_data_s;
        end else begin
            bus.hilo_we_o    = 1'b0;
        end
    end

    // State, counter and latched operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                op_r <= bus.op_i;
                a_r  <= bus.src_a_i;
                b_r  <= bus.src_b_i;
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: a driver issues directed and random
// ops and pushes expected {HI,LO} values; a negedge monitor pops and compares
// on every hilo_we_o pulse.
module tb_hilo_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   last_we_cyc = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv_ctrl_if bus();

    hilo_muldiv_ctrl #(.MUL_CYCLES(2), .DIV_ITERS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure accept-to-write latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        logic [31:0]     q, r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        ia = $signed(a); ib = $signed(b);
        case (op)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) begin
                    r = a;
                    q = a[31] ? 32'd1 : 32'hFFFFFFFF;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    r = 32'd0;
                    q = 32'h80000000;
                end else begin
                    q = ia / ib;
                    r = ia % ib;
                end
                return {r, q};
            end
            3'd3: return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            3'd4: return {a, cur[31:0]};
            3'd5: return {cur[63:32], a};
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: every write pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && bus.hilo_we_o) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", bus.hilo_wdata_o, 64'hx);
            end else begin
                chk("wdata", bus.hilo_wdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] cur);
        bus.op_valid_i = 1'b1;
        bus.op_i       = op;
        bus.src_a_i    = a;
        bus.src_b_i    = b;
        bus.hilo_cur_i = cur;
    endtask

    // Issue one op with stall_ext low; check stall count, write count, latency.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] cur);
        int c0, n0, stalls, exp_st, exp_n;
        bit done;
        @(posedge clk); #1;
        drive(op, a, b, cur);
        c0 = cyc; n0 = we_cnt;
        exp_st = (op <= 3'd1) ? 3 : (op <= 3'd3) ? 33 : 0;
        exp_n  = (op <= 3'd5) ? 1 : 0;
        if (exp_n == 1) exp_q.push_back(model(op, a, b, cur));
        stalls = 0; done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            if (bus.stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.op_valid_i = 1'b0;
        chk({name, "_stalls"}, 64'(stalls), 64'(exp_st));
        chk({name, "_we_count"}, 64'(we_cnt - n0), 64'(exp_n));
        if (exp_n == 1) chk({name, "_latency"}, 64'(last_we_cyc - c0), 64'(exp_st));
    endtask

    function automatic logic [31:0] rand_operand();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n0, stalls;
        bit done;
        bus.op_valid_i = 1'b0; bus.op_i = 3'd0; bus.src_a_i = 32'd0; bus.src_b_i = 32'd0;
        bus.hilo_cur_i = 64'd0; bus.flush_i = 1'b0; bus.stall_ext_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.stall_o, bus.hilo_we_o, bus.hilo_wdata_o}, 66'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op("mult_neg2x3", 3'd0, 32'hFFFFFFFE, 32'd3, 64'd0);
        chk("mult_neg2x3_model", model(3'd0, 32'hFFFFFFFE, 32'd3, 64'd0), 64'hFFFFFFFF_FFFFFFFA);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 64'd0);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 64'd0);
        run_op("mthi", 3'd4, 32'h12345678, 32'd0, 64'hAAAAAAAA_BBBBBBBB);
        run_op("mtlo", 3'd5, 32'hCAFEF00D, 32'd0, 64'hAAAAAAAA_BBBBBBBB);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0);
        run_op("divu_by0", 3'd3, 32'd5, 32'd0, 64'd0);
        run_op("div_neg_by0", 3'd2, 32'hFFFFFFFB, 32'd0, 64'd0);
        run_op("noop_op6", 3'd6, 32'd1, 32'd2, 64'd0);

        // Flush at the tenth busy cycle of a DIV: no write, stall drops.
        @(posedge clk); #1;
        drive(3'd2, 32'd1000, 32'd3, 64'd0);
        n0 = we_cnt;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1; bus.op_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_cycle", {bus.stall_o, bus.hilo_we_o}, 2'b00);
        @(posedge clk); #1 bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_after_stall", {63'd0, bus.stall_o}, 64'd0);
        repeat (40) @(posedge clk);
        chk("flush_no_we", 64'(we_cnt - n0), 64'd0);

        // MULTU completing under an external stall: one pulse, then HOLD.
        @(posedge clk); #1;
        bus.stall_ext_i = 1'b1;
        drive(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
        exp_q.push_back(model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0));
        n0 = we_cnt; stalls = 0; done = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            @(negedge clk);
            if (bus.stall_o) stalls++;
            else done = 1'b1;
        end
        chk("hold_stalls", 64'(stalls), 64'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_quiet", {bus.stall_o, bus.hilo_we_o}, 2'b00);
        end
        @(posedge clk); #1 bus.stall_ext_i = 1'b0; bus.op_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        chk("hold_one_we", 64'(we_cnt - n0), 64'd1);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op("rand", op, rand_operand(), rand_operand(),
                   {$urandom(), $urandom()});
        end

        // Async reset mid-divide: outputs clear at once and no write follows.
        @(posedge clk); #1;
        drive(3'd3, 32'd5, 32'd0, 64'd0);
        n0 = we_cnt;
        repeat (5) @(posedge clk);
        #2 bus.op_valid_i = 1'b0; rst_n = 1'b0;
        #1 chk("reset_midop", {bus.stall_o, bus.hilo_we_o, bus.hilo_wdata_o}, 66'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        chk("reset_no_we", 64'(we_cnt - n0), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
